// File: rtl/sccb_pkg.sv
// Shared SCCB/OV7670 constants and the init-sequencer state type.
package sccb_pkg;

  localparam logic [1:0]  MODE_WR3     = 2'b00;
  localparam logic [1:0]  MODE_WR2     = 2'b01;
  localparam logic [1:0]  MODE_RD2     = 2'b11;

  localparam logic [7:0]  OV7670_WR_ID = 8'h42;

  localparam logic [15:0] TBL_END      = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY    = 16'hFFF0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_rom.sv
// OV7670 power-up register table: soft reset, settle delay, RGB output setup.
module ov7670_init_rom
  import sccb_pkg::*;
#(
  parameter int TABLE_DEPTH = 128
) (
  input  logic                           clk,
  input  logic [$clog2(TABLE_DEPTH)-1:0] idx,
  output logic [15:0]                    entry
);

  logic [15:0] r_entry;

  // Entries past the end of the table read as END so a short table terminates.
  always_ff @(posedge clk) begin
    case (int'(idx))
      0:       r_entry <= 16'h1280;
      1:       r_entry <= TBL_DELAY;
      2:       r_entry <= 16'h1204;
      3:       r_entry <= 16'h3A04;
      default: r_entry <= TBL_END;
    endcase
  end

  assign entry = r_entry;

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the OV7670 init table and issues one SCCB 3-phase write per entry.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR     = OV7670_WR_ID,
  parameter int         TABLE_DEPTH  = 128,
  parameter int         GAP_CYCLES   = 64,
  parameter int         DELAY_CYCLES = 500000,
  parameter int         ACK_TIMEOUT  = 1024,
  localparam int        IDX_W        = $clog2(TABLE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_usher,
  output logic [7:0]       o_address,
  output logic [7:0]       o_subaddress,
  output logic [7:0]       o_data,
  output logic [1:0]       o_mode,
  input  logic             i_busy,
  output logic             o_active,
  output logic             o_done,
  output logic             o_error,
  output logic [IDX_W-1:0] o_index
);

  localparam int CNT_W = $clog2(max3(DELAY_CYCLES, GAP_CYCLES, ACK_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TABLE_DEPTH - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [IDX_W-1:0] r_index;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_sub;
  logic [7:0]       r_data;
  logic             r_usher;
  logic [15:0]      w_entry;
  logic             w_parked;
  logic             w_advance;

  ov7670_init_rom #(
    .TABLE_DEPTH(TABLE_DEPTH)
  ) u_rom (
    .clk  (clk),
    .idx  (r_index),
    .entry(w_entry)
  );

  assign w_parked  = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_advance = ((r_state == ST_GAP) || (r_state == ST_DELAY)) && (w_next == ST_FETCH);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (i_start) w_next = ST_FETCH;
      ST_FETCH:                   w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_entry == TBL_END)        w_next = ST_DONE;
        else if (w_entry == TBL_DELAY) w_next = ST_DELAY;
        else                           w_next = ST_ISSUE;
      end
      // A master still busy from an earlier transfer holds off the usher.
      ST_ISSUE:                   if (!i_busy) w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i_busy)                  w_next = ST_WAIT_DONE;
        else if (r_count == ACK_LAST) w_next = ST_ERROR;
      end
      ST_WAIT_DONE:               if (!i_busy) w_next = ST_GAP;
      ST_GAP:   if (r_count == GAP_LAST)   w_next = (r_index == IDX_LAST) ? ST_DONE : ST_FETCH;
      ST_DELAY: if (r_count == DELAY_LAST) w_next = (r_index == IDX_LAST) ? ST_DONE : ST_FETCH;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_count <= '0;
      r_sub   <= '0;
      r_data  <= '0;
      r_usher <= 1'b0;
    end else begin
      r_state <= w_next;
      r_usher <= (r_state == ST_ISSUE) && !i_busy;
      // Every timed state starts counting from zero; the count saturates.
      if (w_next != r_state)             r_count <= '0;
      else if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
      if (w_parked && i_start)           r_index <= '0;
      else if (w_advance)                r_index <= r_index + 1'b1;
      if ((r_state == ST_DECODE) && (w_next == ST_ISSUE)) begin
        r_sub  <= w_entry[15:8];
        r_data <= w_entry[7:0];
      end
    end
  end

  assign o_usher      = r_usher;
  assign o_address    = DEV_ADDR;
  assign o_subaddress = r_sub;
  assign o_data       = r_data;
  assign o_mode       = MODE_WR3;
  assign o_active     = !w_parked;
  assign o_done       = (r_state == ST_DONE);
  assign o_error      = (r_state == ST_ERROR);
  assign o_index      = r_index;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench: randomized SCCB master model against a table-walk reference.
module tb_sccb_init_sequencer;

  localparam int DELAY_N = 200;
  localparam int ACK_N   = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, startMain, startShort, forceBusy, busyModel, masterOn;
  logic busy;
  assign busy = forceBusy | busyModel;

  logic       mUsher, mActive, mDone, mError;
  logic [7:0] mAddress, mSub, mData;
  logic [1:0] mMode;
  logic [6:0] mIndex;
  logic       sUsher, sActive, sDone, sError;
  logic [7:0] sAddress, sSub, sData;
  logic [1:0] sMode;
  logic [1:0] sIndex;

  sccb_init_sequencer #(.DELAY_CYCLES(DELAY_N)) dut (
    .clk(clk), .rst_n(rstN), .i_start(startMain), .o_usher(mUsher),
    .o_address(mAddress), .o_subaddress(mSub), .o_data(mData), .o_mode(mMode),
    .i_busy(busy), .o_active(mActive), .o_done(mDone), .o_error(mError),
    .o_index(mIndex)
  );

  sccb_init_sequencer #(.TABLE_DEPTH(4), .DELAY_CYCLES(DELAY_N)) dutShort (
    .clk(clk), .rst_n(rstN), .i_start(startShort), .o_usher(sUsher),
    .o_address(sAddress), .o_subaddress(sSub), .o_data(sData), .o_mode(sMode),
    .i_busy(busy), .o_active(sActive), .o_done(sDone), .o_error(sError),
    .o_index(sIndex)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unstable = 0;
  int regress = 0;
  int expEnd = 0;
  int errCyc, elapsed, gap;
  logic [23:0] seenQ[$];
  int          seenCyc[$];
  logic [23:0] expQ[$];
  logic [15:0] romImage [5] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h3A04, 16'hFFFF};

  function automatic logic [15:0] tableAt(input int i);
    return (i < 5) ? romImage[i] : 16'hFFFF;
  endfunction

  // Reference: walk the table by its rules, stopping at END or the last slot.
  function automatic void buildExpected(input int depth);
    expQ.delete();
    expEnd = depth - 1;
    for (int i = 0; i < depth; i++) begin
      if (tableAt(i) == 16'hFFFF) begin
        expEnd = i;
        break;
      end
      if (tableAt(i) != 16'hFFF0) expQ.push_back({8'h42, tableAt(i)});
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSequence(input string tag);
    checkOutput({tag, "_count"}, seenQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < seenQ.size(); i++)
      checkOutput($sformatf("%s_w%0d", tag, i), 32'(seenQ[i]), 32'(expQ[i]));
  endtask

  task automatic applyStimulus(input bit toShort);
    @(negedge clk);
    if (toShort) startShort = 1'b1; else startMain = 1'b1;
    @(negedge clk);
    startShort = 1'b0;
    startMain  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Records every usher with its cycle, and watches address stability and index order.
  initial begin : monitor
    logic [15:0] prevMain;
    logic [1:0]  prevIdx;
    prevMain = '0;
    prevIdx  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mUsher) begin
        seenQ.push_back({mAddress, mSub, mData});
        seenCyc.push_back(cyc);
        if ({mSub, mData} !== prevMain) unstable++;
      end
      if (sUsher) begin
        seenQ.push_back({sAddress, sSub, sData});
        seenCyc.push_back(cyc);
      end
      if (sActive && sIndex < prevIdx) regress++;
      prevMain = {mSub, mData};
      prevIdx  = sIndex;
    end
  end

  // Model SCCB master: random latency before busy, random busy length.
  initial begin : master
    busyModel = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ((mUsher || sUsher) && masterOn) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 busyModel = 1'b1;
        repeat ($urandom_range(5, 25)) @(posedge clk);
        #1 busyModel = 1'b0;
      end
    end
  end

  initial begin
    rstN = 1'b0; startMain = 1'b0; startShort = 1'b0;
    forceBusy = 1'b0; masterOn = 1'b1;
    waitCycles(3);
    checkOutput("rst_usher",   32'(mUsher),   0);
    checkOutput("rst_sub",     32'(mSub),     0);
    checkOutput("rst_data",    32'(mData),    0);
    checkOutput("rst_active",  32'(mActive),  0);
    checkOutput("rst_done",    32'(mDone),    0);
    checkOutput("rst_error",   32'(mError),   0);
    checkOutput("rst_index",   32'(mIndex),   0);
    checkOutput("rst_address", 32'(mAddress), 32'h42);
    checkOutput("rst_mode",    32'(mMode),    0);
    @(negedge clk) rstN = 1'b1;
    waitCycles(2 + $urandom_range(0, 10));

    // Basic run, with a stray start pulse in the middle that must be ignored.
    buildExpected(128);
    seenQ.delete(); seenCyc.delete(); unstable = 0;
    applyStimulus(0);
    checkOutput("basic_active", 32'(mActive), 1);
    for (int c = 0; c < 2000 && seenQ.size() < 1; c++) @(negedge clk);
    waitCycles($urandom_range(0, 150));
    checkOutput("stray_active", 32'(mActive), 1);
    applyStimulus(0);
    for (int c = 0; c < 5000 && !mDone; c++) @(negedge clk);
    checkOutput("basic_done",   32'(mDone),   1);
    checkOutput("basic_idle",   32'(mActive), 0);
    checkOutput("basic_index",  32'(mIndex),  32'(expEnd));
    checkSequence("basic");
    gap = (seenCyc.size() >= 2) ? seenCyc[1] - seenCyc[0] : 0;
    checkOutput("basic_delay_span", 32'(gap >= DELAY_N), 1);
    checkOutput("basic_sub_stable", 32'(unstable), 0);

    // Silent master: ack timeout, then a fresh start clears the error.
    masterOn = 1'b0;
    seenQ.delete(); seenCyc.delete();
    applyStimulus(0);
    for (int c = 0; c < ACK_N + 200 && !mError; c++) @(negedge clk);
    errCyc = cyc;
    checkOutput("to_error",  32'(mError),  1);
    checkOutput("to_active", 32'(mActive), 0);
    checkOutput("to_done",   32'(mDone),   0);
    checkOutput("to_index",  32'(mIndex),  0);
    checkOutput("to_ushers", seenQ.size(), 1);
    if (seenQ.size() > 0) checkOutput("to_entry0", 32'(seenQ[0]), 32'(expQ[0]));
    elapsed = errCyc - ((seenCyc.size() > 0) ? seenCyc[0] : 0);
    checkOutput("to_length", 32'(elapsed >= ACK_N - 1 && elapsed <= ACK_N + 1), 1);
    masterOn = 1'b1;
    seenQ.delete(); seenCyc.delete();
    applyStimulus(0);
    checkOutput("retry_error_clear", 32'(mError),  0);
    checkOutput("retry_active",      32'(mActive), 1);
    for (int c = 0; c < 5000 && !mDone; c++) @(negedge clk);
    checkOutput("retry_done", 32'(mDone), 1);
    checkSequence("retry");

    // Asynchronous reset while the second write is in flight.
    seenQ.delete(); seenCyc.delete();
    applyStimulus(0);
    for (int c = 0; c < 3000 && seenQ.size() < 2; c++) @(negedge clk);
    for (int c = 0; c < 50 && !busyModel; c++) @(negedge clk);
    waitCycles(2);
    checkOutput("mid_index", 32'(mIndex), 2);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_usher",  32'(mUsher),  0);
    checkOutput("async_sub",    32'(mSub),    0);
    checkOutput("async_data",   32'(mData),   0);
    checkOutput("async_active", 32'(mActive), 0);
    checkOutput("async_done",   32'(mDone),   0);
    checkOutput("async_index",  32'(mIndex),  0);
    waitCycles(2);
    rstN = 1'b1;
    for (int c = 0; c < 50 && busyModel; c++) @(negedge clk);
    seenQ.delete(); seenCyc.delete();
    applyStimulus(0);
    for (int c = 0; c < 5000 && !mDone; c++) @(negedge clk);
    checkOutput("rerun_done", 32'(mDone), 1);
    checkSequence("rerun");

    // Master already busy when the first write is ready to go.
    forceBusy = 1'b1;
    seenQ.delete(); seenCyc.delete();
    applyStimulus(0);
    waitCycles(40);
    checkOutput("held_no_usher", seenQ.size(), 0);
    checkOutput("held_active",   32'(mActive), 1);
    forceBusy = 1'b0;
    waitCycles(10);
    checkOutput("held_one_usher", seenQ.size(), 1);
    for (int c = 0; c < 5000 && !mDone; c++) @(negedge clk);
    checkOutput("held_done", 32'(mDone), 1);
    checkSequence("held");

    // Four-entry table with no END: stops at the last slot without wrapping.
    buildExpected(4);
    seenQ.delete(); seenCyc.delete(); regress = 0;
    applyStimulus(1);
    for (int c = 0; c < 5000 && !sDone; c++) @(negedge clk);
    checkOutput("short_done",    32'(sDone),   1);
    checkOutput("short_active",  32'(sActive), 0);
    checkOutput("short_error",   32'(sError),  0);
    checkOutput("short_index",   32'(sIndex),  32'(expEnd));
    checkOutput("short_regress", 32'(regress), 0);
    checkSequence("short");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
